// File: rtl/cs_measurement_block_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cs_measurement_block_packer : double-banked packer of serial CS measurements
// into 2048-bit blocks with row/column coordinates for the MEMC top.
// Revision: 1.0
// ============================================================================
module cs_measurement_block_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_M      = 128,
    parameter int BLK_COLS   = 80,
    parameter int BLK_ROWS   = 45
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic                        start,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        finish_flag,
    output logic [MAX_M*DATA_WIDTH-1:0] streaming_y_in,
    output logic [7:0]                  columns,
    output logic [7:0]                  rows,
    output logic                        block_valid,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        mode_err
);
    localparam int          C_BUS_W      = MAX_M * DATA_WIDTH;
    localparam logic [0:0]  S_IDLE       = 1'b0;
    localparam logic [0:0]  S_RUN        = 1'b1;
    localparam logic [11:0] C_TOTAL_BLKS = 12'(BLK_COLS * BLK_ROWS);
    localparam logic [7:0]  C_LAST_COL   = 8'(BLK_COLS - 1);
    localparam logic [7:0]  C_LAST_ROW   = 8'(BLK_ROWS - 1);

    logic [0:0]         r_state;
    logic [1:0]         r_mode;
    logic [C_BUS_W-1:0] r_fill_bank;
    logic [7:0]         r_beat_cnt;
    logic               r_fill_full;
    logic [11:0]        r_blk_cnt;
    logic               r_finish_q;

    logic               w_run;
    logic [7:0]         w_m_last;
    logic               w_beat;
    logic               w_last_beat;
    logic               w_full_now;
    logic               w_consume;
    logic               w_swap;
    logic [C_BUS_W-1:0] w_fill_next;

    assign w_run       = (r_state == S_RUN);
    assign busy        = w_run;
    assign w_m_last    = (r_mode == 2'b00) ? 8'(MAX_M / 2 - 1) : 8'(MAX_M - 1);
    assign s_ready     = w_run && !r_fill_full && (r_blk_cnt < C_TOTAL_BLKS);
    assign w_beat      = s_valid && s_ready;
    assign w_last_beat = w_beat && (r_beat_cnt == w_m_last);
    // The final beat counts as "full" in its own cycle so it can swap straight out.
    assign w_full_now  = r_fill_full || w_last_beat;
    assign w_consume   = finish_flag && !r_finish_q && block_valid;
    assign w_swap      = w_full_now && (!block_valid || w_consume);

    always_comb begin
        w_fill_next = (w_beat && r_beat_cnt == 8'd0) ? '0 : r_fill_bank;
        for (int k = 0; k < MAX_M; k++) begin
            if (w_beat && r_beat_cnt == 8'(k))
                w_fill_next[k*DATA_WIDTH +: DATA_WIDTH] = s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_mode         <= 2'b00;
            r_fill_bank    <= '0;
            r_beat_cnt     <= 8'd0;
            r_fill_full    <= 1'b0;
            r_blk_cnt      <= 12'd0;
            r_finish_q     <= 1'b0;
            streaming_y_in <= '0;
            columns        <= 8'd0;
            rows           <= 8'd0;
            block_valid    <= 1'b0;
            frame_done     <= 1'b0;
            mode_err       <= 1'b0;
        end else begin
            r_finish_q <= finish_flag;
            frame_done <= 1'b0;
            if (!w_run) begin
                if (start) begin
                    r_state     <= S_RUN;
                    r_mode      <= mode;
                    mode_err    <= mode[1];
                    r_beat_cnt  <= 8'd0;
                    r_fill_full <= 1'b0;
                    r_blk_cnt   <= 12'd0;
                    block_valid <= 1'b0;
                    columns     <= 8'd0;
                    rows        <= 8'd0;
                end
            end else begin
                if (w_beat) begin
                    r_fill_bank <= w_fill_next;
                    r_beat_cnt  <= w_last_beat ? 8'd0 : r_beat_cnt + 8'd1;
                    if (w_last_beat)
                        r_blk_cnt <= r_blk_cnt + 12'd1;
                end
                r_fill_full <= w_full_now && !w_swap;
                if (w_swap)
                    streaming_y_in <= w_fill_next;

                if (w_consume) begin
                    if (columns == C_LAST_COL) begin
                        columns <= 8'd0;
                        if (rows == C_LAST_ROW) begin
                            rows       <= 8'd0;
                            frame_done <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            rows <= rows + 8'd1;
                        end
                    end else begin
                        columns <= columns + 8'd1;
                    end
                end

                if (w_swap)
                    block_valid <= 1'b1;
                else if (w_consume)
                    block_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cs_measurement_block_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_cs_measurement_block_packer : directed self-checking bench for the packer.
// Revision: 1.0
// ============================================================================
module tb_cs_measurement_block_packer;
    localparam int DW     = 16;
    localparam int MM     = 128;
    localparam int COLS   = 80;
    // Three block rows keep a full frame short while still crossing the column wrap.
    localparam int ROWS_N = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       mode = 2'b00;
    logic             start = 1'b0;
    logic [DW-1:0]    s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             finish_flag = 1'b0;
    logic [MM*DW-1:0] streaming_y_in;
    logic [7:0]       columns;
    logic [7:0]       rows;
    logic             block_valid;
    logic             frame_done;
    logic             busy;
    logic             mode_err;

    int total = 0;
    int bad   = 0;

    cs_measurement_block_packer #(
        .DATA_WIDTH(DW), .MAX_M(MM), .BLK_COLS(COLS), .BLK_ROWS(ROWS_N)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .finish_flag(finish_flag), .streaming_y_in(streaming_y_in),
        .columns(columns), .rows(rows), .block_valid(block_valid),
        .frame_done(frame_done), .busy(busy), .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane(input int k);
        return streaming_y_in[k*DW +: DW];
    endfunction

    task automatic check_lanes(input string tag, input logic [15:0] base, input int n);
        for (int k = 0; k < MM; k++)
            chk($sformatf("%s_lane%0d", tag, k), 32'(lane(k)), (k < n) ? 32'(base | 16'(k)) : 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat transferred.
    task automatic send_beat(input logic [15:0] d);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000)
            chk("s_ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_block(input int n, input logic [15:0] base, input bit idle_chk);
        for (int k = 0; k < n; k++) begin
            if (idle_chk && k == n - 1)
                chk("bv_before_last_beat", 32'(block_valid), 32'd0);
            send_beat(base | 16'(k));
        end
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(posedge clk); #1;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_finish();
        @(posedge clk); #1;
        finish_flag = 1'b1;
        @(posedge clk); #1;
        finish_flag = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_bv", 32'(block_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_mode_err", 32'(mode_err), 0);
        chk("rst_cols", 32'(columns), 0);
        chk("rst_rows", 32'(rows), 0);
        chk("rst_bus_zero", 32'(streaming_y_in == '0), 1);
        rst = 1'b0;

        // Frame A, M=128: first block presented one cycle after beat 127
        pulse_start(2'b01);
        chk("a_busy", 32'(busy), 1);
        chk("a_mode_err", 32'(mode_err), 0);
        chk("a_s_ready", 32'(s_ready), 1);
        send_block(MM, 16'h0000, 1'b1);
        chk("t1_bv", 32'(block_valid), 1);
        chk("t1_cols", 32'(columns), 0);
        chk("t1_rows", 32'(rows), 0);
        check_lanes("t1", 16'h0000, MM);

        // START while busy must not relatch MODE or restart the frame
        pulse_start(2'b00);
        send_block(MM, 16'h0100, 1'b0);
        chk("t3_s_ready_full", 32'(s_ready), 0);
        chk("t3_bv_held", 32'(block_valid), 1);
        chk("t3_cols_held", 32'(columns), 0);
        chk("t3_lane5_held", 32'(lane(5)), 32'h0005);

        s_data  = 16'hDEAD;
        s_valid = 1'b1;
        pulse_finish();
        chk("t3_cols_adv", 32'(columns), 1);
        chk("t3_bv_no_gap", 32'(block_valid), 1);
        chk("t3_lane0_new", 32'(lane(0)), 32'h0100);
        chk("t3_lane5_new", 32'(lane(5)), 32'h0105);
        chk("t3_s_ready_back", 32'(s_ready), 1);
        s_valid = 1'b0;

        // FINISH_FLAG held for five cycles advances exactly once
        send_block(MM, 16'h0300, 1'b0);
        @(posedge clk); #1;
        finish_flag = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        finish_flag = 1'b0;
        @(posedge clk); #1;
        chk("t5_cols_once", 32'(columns), 2);
        chk("t5_bv", 32'(block_valid), 1);
        chk("t5_lane7", 32'(lane(7)), 32'h0307);

        // Asynchronous reset in the middle of a fill
        for (int k = 0; k < 50; k++)
            send_beat(16'h0400 | 16'(k));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_s_ready", 32'(s_ready), 0);
        chk("t6_bv", 32'(block_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_cols", 32'(columns), 0);
        chk("t6_rows", 32'(rows), 0);
        chk("t6_mode_err", 32'(mode_err), 0);
        chk("t6_bus_zero", 32'(streaming_y_in == '0), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame B, MODE=10: error flagged, M=128, run to end of frame
        pulse_start(2'b10);
        chk("b_mode_err", 32'(mode_err), 1);
        chk("b_busy", 32'(busy), 1);
        for (int b = 0; b < COLS * ROWS_N; b++) begin
            send_block(MM, 16'(b << 8), 1'b1);
            if (b == 0) begin
                check_lanes("t6_restart", 16'h0000, MM);
                pulse_finish();
            end else if (b == COLS - 1) begin
                chk("t4_cols_79", 32'(columns), 79);
                chk("t4_rows_0", 32'(rows), 0);
                pulse_finish();
                chk("t4_cols_wrap", 32'(columns), 0);
                chk("t4_rows_inc", 32'(rows), 1);
                chk("t4_bv_drop", 32'(block_valid), 0);
            end else if (b == COLS * ROWS_N - 1) begin
                chk("t4_last_rows", 32'(rows), ROWS_N - 1);
                chk("t4_last_cols", 32'(columns), COLS - 1);
                chk("t4_all_filled", 32'(s_ready), 0);
                pulse_finish();
                chk("t4_frame_done", 32'(frame_done), 1);
                chk("t4_busy_end", 32'(busy), 0);
                chk("t4_rows_end", 32'(rows), 0);
                chk("t4_cols_end", 32'(columns), 0);
                chk("t4_bv_end", 32'(block_valid), 0);
                @(posedge clk); #1;
                chk("t4_frame_done_pulse", 32'(frame_done), 0);
                chk("t4_idle_s_ready", 32'(s_ready), 0);
                chk("t4_bus_held", 32'(lane(5)), 32'hEF05);
            end else begin
                pulse_finish();
            end
        end

        // Frame C, M=64: upper lanes cleared despite the previous full-width block
        pulse_start(2'b00);
        chk("c_mode_err_clr", 32'(mode_err), 0);
        chk("c_busy", 32'(busy), 1);
        send_block(MM / 2, 16'hFFFF, 1'b1);
        chk("t2_bv", 32'(block_valid), 1);
        check_lanes("t2", 16'hFFFF, MM / 2);
        send_block(MM / 2, 16'h0A00, 1'b0);
        chk("t2_second_full", 32'(s_ready), 0);
        pulse_finish();
        chk("t2_cols", 32'(columns), 1);
        chk("t2_bv_no_gap", 32'(block_valid), 1);
        check_lanes("t2b", 16'h0A00, MM / 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
